// File: rtl/foc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : foc_pkg
// Purpose  : Shared Q1.15 widths, rounding constant, quadrant encoding and
//            the 64-segment quarter-wave sine table for the FOC datapath.
// Revision : 1.0 - initial release
// ============================================================================
package foc_pkg;

    localparam int Q15_W      = 16;
    localparam int Q15_FRAC   = 15;
    localparam int PROD_W     = 2 * Q15_W;
    localparam int SUM_W      = PROD_W + 1;
    localparam int LUT_AW_MAX = 6;

    localparam logic signed [Q15_W-1:0] Q15_MAX   = 16'sh7FFF;
    localparam logic signed [Q15_W-1:0] Q15_MIN   = 16'sh8000;
    localparam logic        [Q15_W-1:0] ROUND_Q15 = 16'h4000;

    // theta[15:14]: which quarter of the electrical revolution
    typedef enum logic [1:0] {
        QUAD_I   = 2'd0,
        QUAD_II  = 2'd1,
        QUAD_III = 2'd2,
        QUAD_IV  = 2'd3
    } quad_t;

    // round(32767*sin(k*pi/128)), k = 0..64; +1.0 saturates to 32767
    function automatic logic [14:0] sin_q15_table(input logic [LUT_AW_MAX:0] k);
        logic [14:0] t;
        t = '0;
        case (k)
            7'd0:  t = 15'd0;     7'd1:  t = 15'd804;   7'd2:  t = 15'd1608;  7'd3:  t = 15'd2410;
            7'd4:  t = 15'd3212;  7'd5:  t = 15'd4011;  7'd6:  t = 15'd4808;  7'd7:  t = 15'd5602;
            7'd8:  t = 15'd6393;  7'd9:  t = 15'd7179;  7'd10: t = 15'd7962;  7'd11: t = 15'd8739;
            7'd12: t = 15'd9512;  7'd13: t = 15'd10278; 7'd14: t = 15'd11039; 7'd15: t = 15'd11793;
            7'd16: t = 15'd12539; 7'd17: t = 15'd13279; 7'd18: t = 15'd14010; 7'd19: t = 15'd14732;
            7'd20: t = 15'd15446; 7'd21: t = 15'd16151; 7'd22: t = 15'd16846; 7'd23: t = 15'd17530;
            7'd24: t = 15'd18204; 7'd25: t = 15'd18868; 7'd26: t = 15'd19519; 7'd27: t = 15'd20159;
            7'd28: t = 15'd20787; 7'd29: t = 15'd21403; 7'd30: t = 15'd22005; 7'd31: t = 15'd22594;
            7'd32: t = 15'd23170; 7'd33: t = 15'd23731; 7'd34: t = 15'd24279; 7'd35: t = 15'd24811;
            7'd36: t = 15'd25329; 7'd37: t = 15'd25832; 7'd38: t = 15'd26319; 7'd39: t = 15'd26790;
            7'd40: t = 15'd27245; 7'd41: t = 15'd27683; 7'd42: t = 15'd28105; 7'd43: t = 15'd28510;
            7'd44: t = 15'd28898; 7'd45: t = 15'd29268; 7'd46: t = 15'd29621; 7'd47: t = 15'd29956;
            7'd48: t = 15'd30273; 7'd49: t = 15'd30571; 7'd50: t = 15'd30852; 7'd51: t = 15'd31113;
            7'd52: t = 15'd31356; 7'd53: t = 15'd31580; 7'd54: t = 15'd31785; 7'd55: t = 15'd31971;
            7'd56: t = 15'd32137; 7'd57: t = 15'd32285; 7'd58: t = 15'd32412; 7'd59: t = 15'd32521;
            7'd60: t = 15'd32609; 7'd61: t = 15'd32678; 7'd62: t = 15'd32728; 7'd63: t = 15'd32757;
            7'd64: t = 15'd32767;
            default: t = 15'd0;
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/park_sincos_lut.sv
`default_nettype none
// ============================================================================
// Module   : park_sincos_lut
// Purpose  : Two-read-port registered quarter-wave ROM. Maps quadrant+index
//            to signed Q1.15 sin and cos, one clock after the address.
//            Smaller tables (LUT_AW < 6) subsample the 64-segment table.
// Revision : 1.0 - initial release
// ============================================================================
module park_sincos_lut
    import foc_pkg::*;
#(
    parameter int LUT_AW = 6
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  quad_t                   sin_quad,
    input  logic [LUT_AW-1:0]       sin_idx,
    input  quad_t                   cos_quad,
    input  logic [LUT_AW-1:0]       cos_idx,
    output logic signed [Q15_W-1:0] sin_q15,
    output logic signed [Q15_W-1:0] cos_q15
);

    localparam int N         = 1 << LUT_AW;
    localparam int STRIDE_SH = LUT_AW_MAX - LUT_AW;

    logic signed [Q15_W-1:0] r_sin;
    logic signed [Q15_W-1:0] r_cos;

    // Quadrants II/IV read the table mirrored, III/IV negate the magnitude
    function automatic logic signed [Q15_W-1:0] lookup(input quad_t quad,
                                                       input logic [LUT_AW-1:0] idx);
        logic [LUT_AW:0]         k;
        logic [LUT_AW_MAX:0]     k64;
        logic signed [Q15_W-1:0] mag;
        if (quad == QUAD_II || quad == QUAD_IV) begin
            k = (LUT_AW+1)'(N) - {1'b0, idx};
        end else begin
            k = {1'b0, idx};
        end
        k64 = (LUT_AW_MAX+1)'(k) << STRIDE_SH;
        mag = signed'({1'b0, sin_q15_table(k64)});
        return (quad == QUAD_III || quad == QUAD_IV) ? -mag : mag;
    endfunction

    // Registered read of both ports; holds while the pipe is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sin <= '0;
            r_cos <= '0;
        end else if (en) begin
            r_sin <= lookup(sin_quad, sin_idx);
            r_cos <= lookup(cos_quad, cos_idx);
        end
    end

    assign sin_q15 = r_sin;
    assign cos_q15 = r_cos;

endmodule
`default_nettype wire

// File: rtl/park_transform_pipe.sv
`default_nettype none
// ============================================================================
// Module   : park_transform_pipe
// Purpose  : 4-stage Park transform, i_d = a*cos + b*sin, i_q = b*cos - a*sin,
//            1 sample/clk with whole-pipe valid/ready stall.
//            Build option PARK_SAT_EN: clamp outputs instead of 16-bit wrap.
// Revision : 1.0 - initial release
// ============================================================================
module park_transform_pipe
    import foc_pkg::*;
#(
    parameter int LUT_AW = 6,
    parameter int DW     = 16
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] i_alpha,
    input  logic signed [DW-1:0] i_beta,
    input  logic [15:0]          theta,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] i_d,
    output logic signed [DW-1:0] i_q
);

    localparam int IDX_LSB = 14 - LUT_AW;

    logic                    w_stall;
    logic                    w_en;
    logic [15:0]             w_theta_cos;

    logic                    r1_valid;
    logic signed [DW-1:0]    r1_alpha, r1_beta;
    quad_t                   r1_sin_quad, r1_cos_quad;
    logic [LUT_AW-1:0]       r1_sin_idx, r1_cos_idx;

    logic                    r2_valid;
    logic signed [DW-1:0]    r2_alpha, r2_beta;
    logic signed [Q15_W-1:0] w_sin, w_cos;

    logic                    r3_valid;
    logic signed [PROD_W-1:0] r3_p_ac, r3_p_bs, r3_p_as, r3_p_bc;

    logic signed [SUM_W-1:0] w_sum_d, w_sum_q, w_rnd_d, w_rnd_q, w_shr_d, w_shr_q;
    logic signed [Q15_W-1:0] w_lim_d, w_lim_q;

    logic                    r4_valid;
    logic signed [DW-1:0]    r4_d, r4_q;
    logic                    w_unused;

    // A held output blocks every stage; bubbles travel like samples
    assign w_stall     = r4_valid & ~out_ready;
    assign w_en        = ~w_stall;
    assign in_ready    = w_en;
    assign w_theta_cos = theta + 16'h4000;

    // S1: capture operands and split both angles into quadrant/index
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r1_alpha    <= '0;
            r1_beta     <= '0;
            r1_sin_quad <= QUAD_I;
            r1_cos_quad <= QUAD_I;
            r1_sin_idx  <= '0;
            r1_cos_idx  <= '0;
        end else if (w_en) begin
            r1_valid    <= in_valid;
            r1_alpha    <= i_alpha;
            r1_beta     <= i_beta;
            r1_sin_quad <= quad_t'(theta[15:14]);
            r1_cos_quad <= quad_t'(w_theta_cos[15:14]);
            r1_sin_idx  <= theta[13:IDX_LSB];
            r1_cos_idx  <= w_theta_cos[13:IDX_LSB];
        end
    end

    // S2: the ROM registers sin/cos; operands ride alongside
    park_sincos_lut #(
        .LUT_AW (LUT_AW)
    ) u_lut (
        .clk      (clk),
        .rst      (rst),
        .en       (w_en),
        .sin_quad (r1_sin_quad),
        .sin_idx  (r1_sin_idx),
        .cos_quad (r1_cos_quad),
        .cos_idx  (r1_cos_idx),
        .sin_q15  (w_sin),
        .cos_q15  (w_cos)
    );

    // S2 side-band: delay valid and operands to line up with the ROM output
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_alpha <= '0;
            r2_beta  <= '0;
        end else if (w_en) begin
            r2_valid <= r1_valid;
            r2_alpha <= r1_alpha;
            r2_beta  <= r1_beta;
        end
    end

    // S3: four Q2.30 products
    always_ff @(posedge clk) begin
        if (rst) begin
            r3_valid <= 1'b0;
            r3_p_ac  <= '0;
            r3_p_bs  <= '0;
            r3_p_as  <= '0;
            r3_p_bc  <= '0;
        end else if (w_en) begin
            r3_valid <= r2_valid;
            r3_p_ac  <= PROD_W'(r2_alpha) * PROD_W'(w_cos);
            r3_p_bs  <= PROD_W'(r2_beta)  * PROD_W'(w_sin);
            r3_p_as  <= PROD_W'(r2_alpha) * PROD_W'(w_sin);
            r3_p_bc  <= PROD_W'(r2_beta)  * PROD_W'(w_cos);
        end
    end

    // S4 combinational: 33-bit sums, round half up, back to Q1.15 scale
    always_comb begin
        w_sum_d = SUM_W'(r3_p_ac) + SUM_W'(r3_p_bs);
        w_sum_q = SUM_W'(r3_p_bc) - SUM_W'(r3_p_as);
        w_rnd_d = w_sum_d + SUM_W'(ROUND_Q15);
        w_rnd_q = w_sum_q + SUM_W'(ROUND_Q15);
        w_shr_d = w_rnd_d >>> Q15_FRAC;
        w_shr_q = w_rnd_q >>> Q15_FRAC;
    end

`ifdef PARK_SAT_EN
    // Clamp the scaled sums into the Q1.15 range
    always_comb begin
        w_lim_d = w_shr_d[Q15_W-1:0];
        w_lim_q = w_shr_q[Q15_W-1:0];
        if (w_shr_d > SUM_W'(Q15_MAX)) w_lim_d = Q15_MAX;
        else if (w_shr_d < SUM_W'(Q15_MIN)) w_lim_d = Q15_MIN;
        if (w_shr_q > SUM_W'(Q15_MAX)) w_lim_q = Q15_MAX;
        else if (w_shr_q < SUM_W'(Q15_MIN)) w_lim_q = Q15_MIN;
    end

    assign w_unused = ^{theta[IDX_LSB-1:0], w_theta_cos[IDX_LSB-1:0]};
`else
    // Two's-complement wrap; callers keep |a|,|b| small enough to avoid it
    assign w_lim_d  = w_shr_d[Q15_W-1:0];
    assign w_lim_q  = w_shr_q[Q15_W-1:0];
    assign w_unused = ^{theta[IDX_LSB-1:0], w_theta_cos[IDX_LSB-1:0],
                        w_shr_d[SUM_W-1:Q15_W], w_shr_q[SUM_W-1:Q15_W]};
`endif

    // S4: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r4_valid <= 1'b0;
            r4_d     <= '0;
            r4_q     <= '0;
        end else if (w_en) begin
            r4_valid <= r3_valid;
            r4_d     <= w_lim_d;
            r4_q     <= w_lim_q;
        end
    end

    assign out_valid = r4_valid;
    assign i_d       = r4_d;
    assign i_q       = r4_q;

endmodule
`default_nettype wire

// File: tb/tb_park_transform_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_park_transform_pipe
// Purpose  : Self-checking bench for park_transform_pipe: directed vector
//            table, back-to-back, stall, mid-flight reset and random traffic
//            against a floating-point-table arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_park_transform_pipe;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready;
    logic signed [15:0] i_alpha, i_beta, i_d, i_q;
    logic [15:0] theta;

    int errors = 0;
    int checks = 0;
    int tbl[0:64];

    typedef struct {
        logic [15:0] theta;
        int a;
        int b;
        int exp_d;
        int exp_q;
    } vec_t;
    vec_t vecs[7];

    typedef struct {
        int d;
        int q;
    } res_t;
    res_t sb[$];
    bit sb_on = 1'b0;
    int n_in  = 0;
    int n_out = 0;

    park_transform_pipe #(.LUT_AW(6), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_alpha   (i_alpha),
        .i_beta    (i_beta),
        .theta     (theta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .i_d       (i_d),
        .i_q       (i_q)
    );

    always #5 clk = ~clk;

    // sine of angle m*2*pi/256 from the quarter table
    function automatic int sin_model(int m);
        int r;
        int qd;
        r  = m % 64;
        qd = (m / 64) % 4;
        case (qd)
            0:       return tbl[r];
            1:       return tbl[64 - r];
            2:       return -tbl[r];
            default: return -tbl[64 - r];
        endcase
    endfunction

    function automatic int limit16(longint v);
        longint w;
`ifdef PARK_SAT_EN
        w = v;
        if (w > 32767) w = 32767;
        if (w < -32768) w = -32768;
`else
        w = v & 64'hFFFF;
        if (w >= 32768) w = w - 65536;
`endif
        return int'(w);
    endfunction

    function automatic res_t model(logic [15:0] th, int a, int b);
        int m;
        longint s, c, d, q;
        res_t r;
        m = int'(th) >> 8;
        s = sin_model(m);
        c = sin_model((m + 64) % 256);
        d = longint'(a) * c + longint'(b) * s;
        q = longint'(b) * c - longint'(a) * s;
        r.d = limit16((d + 16384) >>> 15);
        r.q = limit16((q + 16384) >>> 15);
        return r;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: scoreboard bookkeeping before the edge, settle after it
    task automatic tick();
        #1;
        if (sb_on) begin
            if (rst) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got d=%0d q=%0d expected no output", i_d, i_q);
                    end else begin
                        res_t e;
                        e = sb.pop_front();
                        check("sb_d", int'(i_d), e.d);
                        check("sb_q", int'(i_q), e.q);
                    end
                end
                if (in_valid && in_ready) begin
                    n_in++;
                    sb.push_back(model(theta, int'(i_alpha), int'(i_beta)));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        int lim;
`ifdef PARK_SAT_EN
        lim = 32767;
`else
        lim = 23170;
`endif
        theta   = 16'($urandom);
        i_alpha = 16'(int'($urandom_range(2 * lim, 0)) - lim);
        i_beta  = 16'(int'($urandom_range(2 * lim, 0)) - lim);
    endtask

    task automatic drain(string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 30 && sb.size() > 0; k++) tick();
        check(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, first, last, cnt, in0, out0, hold_d, hold_q, seen;

        for (int k = 0; k <= 64; k++)
            tbl[k] = $rtoi(32767.0 * $sin(real'(k) * 3.14159265358979 / 128.0) + 0.5);

        // +0x4000 then >>>15 rounds the -16383.5 cases up to -16383
        vecs[0] = '{16'h0000, 16384, 0, 16384, 0};
        vecs[1] = '{16'h4000, 16384, 0, 0, -16383};
        vecs[2] = '{16'h8000, 16384, 0, -16383, 0};
`ifdef PARK_SAT_EN
        vecs[3] = '{16'h2000, 32767, 32767, 32767, 0};
`else
        vecs[3] = '{16'h2000, 32767, 32767, -19197, 0};
`endif
        vecs[4] = '{16'hC000, 0, 16384, -16383, 0};
        vecs[5] = '{16'hFFFF, 16384, 0, 16379, 402};
        vecs[6] = '{16'h10FF, -8192, 4096, -6001, 6919};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        theta = '0; i_alpha = '0; i_beta = '0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_i_d", int'(i_d), 0);
        check("reset_i_q", int'(i_q), 0);
        check("reset_in_ready", int'(in_ready), 1);

        // Directed vectors, one sample at a time
        foreach (vecs[i]) begin
            theta    = vecs[i].theta;
            i_alpha  = 16'(vecs[i].a);
            i_beta   = 16'(vecs[i].b);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 12) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_i_d", i), int'(i_d), vecs[i].exp_d);
            check($sformatf("vec%0d_i_q", i), int'(i_q), vecs[i].exp_q);
            tick();
        end

        // 16 back-to-back samples
        sb_on = 1'b1;
        first = -1; last = -1; cnt = 0;
        for (int t = 0; t < 26; t++) begin
            if (t < 16) begin
                rand_inputs();
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (out_valid) begin
                if (first < 0) first = t;
                last = t;
                cnt++;
            end
        end
        check("b2b_count", cnt, 16);
        check("b2b_contiguous", last - first + 1, 16);
        check("b2b_first_latency", first, 3);
        drain("b2b_drain");

        // Full pipe held for 3 clocks
        in0 = n_in; out0 = n_out;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_inputs();
            in_valid = 1'b1;
            tick();
        end
        check("stall_pipe_full", int'(out_valid), 1);
        out_ready = 1'b0;
        hold_d = int'(i_d);
        hold_q = int'(i_q);
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            tick();
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_i_d", int'(i_d), hold_d);
            check("stall_i_q", int'(i_q), hold_q);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rand_inputs();
            tick();
        end
        drain("stall_drain");
        check("stall_in_out_balance", n_out - out0, n_in - in0);

        // Reset with 3 samples in flight
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("flush_out_valid", int'(out_valid), 0);
        check("flush_i_d", int'(i_d), 0);
        check("flush_i_q", int'(i_q), 0);
        check("flush_in_ready", int'(in_ready), 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("flush_no_ghost", seen, 0);

        // Random traffic with random backpressure
        for (int t = 0; t < 400; t++) begin
            rand_inputs();
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(2, 0) != 0);
            tick();
        end
        drain("random_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
